// File: rtl/cfg_region_pkg.sv
// Shared types for the sequential PMA region scanner.
package cfg_region_pkg;

  typedef struct packed {
    logic exec;
    logic cached;
    logic nonidem;
  } region_attr_t;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StResp
  } scan_state_e;

  function automatic int unsigned max_rules(config_pkg::cva6_cfg_t cfg);
    int unsigned m;
    m = cfg.NrExecuteRegionRules;
    if (cfg.NrCachedRegionRules > m) m = cfg.NrCachedRegionRules;
    if (cfg.NrNonIdempotentRules > m) m = cfg.NrNonIdempotentRules;
    return m;
  endfunction

endpackage

// File: rtl/config_pkg.sv
// Minimal core configuration record: physical address width and the PMA region rule tables.
package config_pkg;

  localparam int unsigned NrMaxRules = 16;
  localparam int unsigned RuleIdxW   = 4;

  typedef struct packed {
    int unsigned                      PLEN;
    int unsigned                      NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]      ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]      ExecuteRegionLength;
    int unsigned                      NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]      CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]      CachedRegionLength;
    int unsigned                      NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]      NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]      NonIdempotentLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd34, default: '0};

endpackage

// File: rtl/cfg_region_match.sv
// Combinational range check base <= addr < base + len, sum kept one bit wider than the address.
module cfg_region_match #(
  parameter int unsigned Plen = 34
) (
  input  logic [Plen-1:0] base,
  input  logic [Plen-1:0] len,
  input  logic [Plen-1:0] addr,
  output logic            hit
);

  logic [Plen:0] lo;
  logic [Plen:0] top;
  logic [Plen:0] addr_x;

  // Extra carry bit: a region running past the top of the space cannot wrap onto low addresses.
  assign lo     = {1'b0, base};
  assign top    = lo + {1'b0, len};
  assign addr_x = {1'b0, addr};
  assign hit    = (addr_x >= lo) && (addr_x < top);

endmodule

// File: rtl/cfg_region_scanner.sv
// Classifies one address against the execute/cached/non-idempotent rules, one rule index per cycle.
// Optional CFG_REGION_SCAN_EARLY_EXIT_EN: leave SCAN once every class has already matched.
module cfg_region_scanner
  import cfg_region_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [CVA6Cfg.PLEN-1:0]   req_addr_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [CVA6Cfg.PLEN-1:0]   rsp_addr_o,
  output logic                      rsp_exec_o,
  output logic                      rsp_cached_o,
  output logic                      rsp_nonidem_o,
  output logic [7:0]                rsp_cycles_o
);

  localparam int unsigned Plen     = CVA6Cfg.PLEN;
  localparam int unsigned MaxRules = max_rules(CVA6Cfg);
  localparam int unsigned IdxW     = (MaxRules > 0) ? $clog2(MaxRules + 1) : 1;

  scan_state_e             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  region_attr_t            flags_q, flags_d;
  logic [7:0]              cycles_q, cycles_d;
  logic [Plen-1:0]         addr_q, addr_d;
  logic                    ready_q;
  logic                    valid_q;

  logic [31:0]                       idx_w;
  logic [config_pkg::RuleIdxW-1:0]   rule_sel;
  logic [Plen-1:0]                   exec_base, exec_len;
  logic [Plen-1:0]                   cached_base, cached_len;
  logic [Plen-1:0]                   nonidem_base, nonidem_len;
  logic                              exec_hit, cached_hit, nonidem_hit;
  logic                              scan_done;
  logic                              all_set;

  assign idx_w    = 32'(idx_q);
  assign rule_sel = config_pkg::RuleIdxW'(idx_q);

  // Classes with fewer rules than MaxRules present an empty range once exhausted.
  always_comb begin
    exec_base    = '0;
    exec_len     = '0;
    cached_base  = '0;
    cached_len   = '0;
    nonidem_base = '0;
    nonidem_len  = '0;
    if (idx_w < CVA6Cfg.NrExecuteRegionRules) begin
      exec_base = CVA6Cfg.ExecuteRegionAddrBase[rule_sel][Plen-1:0];
      exec_len  = CVA6Cfg.ExecuteRegionLength[rule_sel][Plen-1:0];
    end
    if (idx_w < CVA6Cfg.NrCachedRegionRules) begin
      cached_base = CVA6Cfg.CachedRegionAddrBase[rule_sel][Plen-1:0];
      cached_len  = CVA6Cfg.CachedRegionLength[rule_sel][Plen-1:0];
    end
    if (idx_w < CVA6Cfg.NrNonIdempotentRules) begin
      nonidem_base = CVA6Cfg.NonIdempotentAddrBase[rule_sel][Plen-1:0];
      nonidem_len  = CVA6Cfg.NonIdempotentLength[rule_sel][Plen-1:0];
    end
  end

  cfg_region_match #(.Plen(Plen)) u_match_exec (
    .base (exec_base),
    .len  (exec_len),
    .addr (addr_q),
    .hit  (exec_hit)
  );

  cfg_region_match #(.Plen(Plen)) u_match_cached (
    .base (cached_base),
    .len  (cached_len),
    .addr (addr_q),
    .hit  (cached_hit)
  );

  cfg_region_match #(.Plen(Plen)) u_match_nonidem (
    .base (nonidem_base),
    .len  (nonidem_len),
    .addr (addr_q),
    .hit  (nonidem_hit)
  );

`ifdef CFG_REGION_SCAN_EARLY_EXIT_EN
  assign all_set = (flags_q.exec    || (CVA6Cfg.NrExecuteRegionRules == 0)) &&
                   (flags_q.cached  || (CVA6Cfg.NrCachedRegionRules  == 0)) &&
                   (flags_q.nonidem || (CVA6Cfg.NrNonIdempotentRules == 0));
`else
  assign all_set = 1'b0;
`endif

  // idx runs 0..MaxRules; the cycle that finds it at MaxRules only hands over to RESP.
  assign scan_done = (idx_w == MaxRules) || all_set;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    flags_d  = flags_q;
    cycles_d = cycles_q;
    addr_d   = addr_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          addr_d   = req_addr_i;
          flags_d  = '0;
          idx_d    = '0;
          cycles_d = '0;
          state_d  = (MaxRules == 0) ? StResp : StScan;
        end
      end
      StScan: begin
        if (scan_done) begin
          state_d = StResp;
        end else begin
          flags_d.exec    = flags_q.exec    | exec_hit;
          flags_d.cached  = flags_q.cached  | cached_hit;
          flags_d.nonidem = flags_q.nonidem | nonidem_hit;
          cycles_d        = (cycles_q == 8'hFF) ? cycles_q : cycles_q + 8'd1;
          idx_d           = idx_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d  = StIdle;
      idx_d    = '0;
      flags_d  = '0;
      cycles_d = '0;
      addr_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      flags_q  <= '0;
      cycles_q <= '0;
      addr_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      flags_q  <= flags_d;
      cycles_q <= cycles_d;
      addr_q   <= addr_d;
      ready_q  <= (state_d == StIdle);
      valid_q  <= (state_d == StResp);
    end
  end

  assign req_ready_o   = ready_q;
  assign rsp_valid_o   = valid_q;
  assign rsp_addr_o    = addr_q;
  assign rsp_exec_o    = flags_q.exec;
  assign rsp_cached_o  = flags_q.cached;
  assign rsp_nonidem_o = flags_q.nonidem;
  assign rsp_cycles_o  = cycles_q;

endmodule
